// File: rtl/midi_note_decoder.sv
// midi_note_decoder: MIDI byte stream to note on/off commands (ports: clk, rst, i_byte_valid, i_byte -> o_valid, o_cmd, o_midi, o_velocity, o_err)
module midi_note_decoder #(
  parameter int CHANNEL = 0,
  parameter int OMNI = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte,
  output logic       o_valid,
  output logic       o_cmd,
  output logic [6:0] o_midi,
  output logic [6:0] o_velocity,
  output logic       o_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_NOTE, S_WAIT_VEL} state_t;
  typedef enum logic [1:0] {RS_NONE, RS_ON, RS_OFF} rs_t;
  localparam logic [3:0] CH = CHANNEL[3:0];
  state_t r_state, w_state_n;
  rs_t r_rs, w_rs_n;
  logic [6:0] r_note, w_note_n;
  logic r_valid, r_cmd, r_err;
  logic [6:0] r_midi, r_vel;
  logic w_rt, w_status, w_match, w_emit, w_err, w_on;
  assign w_rt = i_byte >= 8'hF8;
  assign w_status = i_byte[7] && !w_rt;
  assign w_match = (i_byte[7:4] == 4'h8 || i_byte[7:4] == 4'h9) && (OMNI != 0 || i_byte[3:0] == CH);
  assign w_on = r_rs == RS_ON && i_byte[6:0] != 7'd0;
  always_comb begin
    w_state_n = r_state;
    w_rs_n = r_rs;
    w_note_n = r_note;
    w_emit = 1'b0;
    w_err = 1'b0;
    if (i_byte_valid && w_status) begin
      w_rs_n = !w_match ? RS_NONE : i_byte[4] ? RS_ON : RS_OFF;
      w_state_n = w_match ? S_WAIT_NOTE : S_IDLE;
      w_err = r_state == S_WAIT_VEL;
    end else if (i_byte_valid && !i_byte[7]) begin
      if (r_state == S_WAIT_VEL) begin
        w_emit = 1'b1;
        w_state_n = S_IDLE;
      end else if (r_state == S_WAIT_NOTE || r_rs != RS_NONE) begin
        w_note_n = i_byte[6:0];
        w_state_n = S_WAIT_VEL;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rs <= RS_NONE;
      r_note <= 7'd0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
      r_cmd <= 1'b0;
      r_midi <= 7'd0;
      r_vel <= 7'd0;
    end else begin
      r_state <= w_state_n;
      r_rs <= w_rs_n;
      r_note <= w_note_n;
      r_valid <= w_emit;
      r_err <= w_err;
      if (w_emit) begin
        r_cmd <= w_on;
        r_midi <= r_note;
        r_vel <= w_on ? i_byte[6:0] : 7'd0;
      end
    end
  end
  assign o_valid = r_valid;
  assign o_cmd = r_cmd;
  assign o_midi = r_midi;
  assign o_velocity = r_vel;
  assign o_err = r_err;
endmodule

// File: tb/tb_midi_note_decoder.sv
// tb_midi_note_decoder: random and directed byte streams against a message-level reference model
module tb_midi_note_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_byte_valid = 1'b0;
  logic [7:0] i_byte = 8'h00;
  logic o_valid[2], o_cmd[2], o_err[2];
  logic [6:0] o_midi[2], o_velocity[2];
  int checks = 0;
  int errors = 0;
  int m_rs[2];
  int m_cnt[2];
  logic [6:0] m_note[2];
  logic e_valid[2], e_cmd[2], e_err[2];
  logic [6:0] e_midi[2], e_vel[2];
  always #5 clk = ~clk;
  midi_note_decoder #(.CHANNEL(0), .OMNI(0)) u_ch0 (
    .clk(clk), .rst(rst), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_valid(o_valid[0]), .o_cmd(o_cmd[0]), .o_midi(o_midi[0]), .o_velocity(o_velocity[0]), .o_err(o_err[0])
  );
  midi_note_decoder #(.CHANNEL(0), .OMNI(1)) u_omni (
    .clk(clk), .rst(rst), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_valid(o_valid[1]), .o_cmd(o_cmd[1]), .o_midi(o_midi[1]), .o_velocity(o_velocity[1]), .o_err(o_err[1])
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rs[k] = 0;
      m_cnt[k] = 0;
      m_note[k] = 7'd0;
      e_valid[k] = 1'b0;
      e_err[k] = 1'b0;
      e_cmd[k] = 1'b0;
      e_midi[k] = 7'd0;
      e_vel[k] = 7'd0;
    end
  endtask
  task automatic model_step(input int k, input logic v, input logic [7:0] b);
    logic on;
    logic [3:0] hi;
    e_valid[k] = 1'b0;
    e_err[k] = 1'b0;
    if (!v || b >= 8'hF8) return;
    hi = b[7:4];
    if (b[7]) begin
      e_err[k] = m_cnt[k] == 1;
      m_cnt[k] = 0;
      if ((hi == 4'h8 || hi == 4'h9) && (k == 1 || b[3:0] == 4'h0)) m_rs[k] = hi == 4'h9 ? 1 : 2;
      else m_rs[k] = 0;
    end else if (m_rs[k] != 0) begin
      if (m_cnt[k] == 0) begin
        m_note[k] = b[6:0];
        m_cnt[k] = 1;
      end else begin
        on = m_rs[k] == 1 && b != 8'h00;
        e_valid[k] = 1'b1;
        e_cmd[k] = on;
        e_midi[k] = m_note[k];
        e_vel[k] = on ? b[6:0] : 7'd0;
        m_cnt[k] = 0;
      end
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk(k ? "omni_valid" : "ch0_valid", o_valid[k], e_valid[k]);
      chk(k ? "omni_err" : "ch0_err", o_err[k], e_err[k]);
      chk(k ? "omni_cmd" : "ch0_cmd", o_cmd[k], e_cmd[k]);
      chk(k ? "omni_midi" : "ch0_midi", o_midi[k], e_midi[k]);
      chk(k ? "omni_vel" : "ch0_vel", o_velocity[k], e_vel[k]);
    end
  endtask
  task automatic send(input logic v, input logic [7:0] b);
    @(negedge clk);
    i_byte_valid = v;
    i_byte = b;
    for (int k = 0; k < 2; k++) model_step(k, v, b);
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    i_byte_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int r;
    logic [7:0] b;
    model_reset();
    pulse_reset();
    send(1, 8'h90); send(1, 8'h45); send(1, 8'h64);
    chk("a4_valid", o_valid[0], 1);
    chk("a4_cmd", o_cmd[0], 1);
    chk("a4_midi", o_midi[0], 69);
    chk("a4_vel", o_velocity[0], 100);
    send(0, 8'h00);
    chk("a4_hold_midi", o_midi[0], 69);
    send(1, 8'h4D); send(1, 8'h40);
    chk("rs_midi", o_midi[0], 77);
    chk("rs_vel", o_velocity[0], 64);
    send(1, 8'h90); send(1, 8'h45); send(1, 8'h00);
    chk("v0_cmd", o_cmd[0], 0);
    send(1, 8'h80); send(1, 8'h4D); send(1, 8'h7F);
    chk("off_midi", o_midi[0], 77);
    chk("off_vel", o_velocity[0], 0);
    send(1, 8'h91); send(1, 8'h45); send(1, 8'h64);
    chk("filt_valid", o_valid[0], 0);
    chk("omni_midi69", o_midi[1], 69);
    send(1, 8'hC0); send(1, 8'h05);
    send(1, 8'h90); send(1, 8'h45); send(1, 8'hF8); send(1, 8'h64);
    chk("rt_vel", o_velocity[0], 100);
    send(1, 8'h90); send(1, 8'h45); send(1, 8'h80);
    chk("abort_err", o_err[0], 1);
    send(1, 8'h45); send(1, 8'h10);
    chk("abort_off_cmd", o_cmd[0], 0);
    pulse_reset();
    send(1, 8'h90); send(1, 8'h45);
    pulse_reset();
    send(1, 8'h64);
    chk("rst_mid_valid", o_valid[0], 0);
    chk("rst_mid_midi", o_midi[0], 0);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 11);
      b = 8'($urandom_range(0, 127));
      if (r == 0) send(0, 8'($urandom));
      else if (r == 1) send(1, 8'hF8 | 8'($urandom_range(0, 7)));
      else if (r <= 4) send(1, (r == 2 ? 8'h80 : 8'h90) | 8'($urandom_range(0, 1)));
      else if (r == 5) send(1, 8'($urandom_range(8'hA0, 8'hF7)));
      else if (r == 6) send(1, 8'h00);
      else send(1, b);
      if (n == 1500) pulse_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
